// File: rtl/mesh_term_pkg.sv
// Shared definitions for the mesh terminal receiver: the packet field map, the
// receive FSM state encoding and a header struct for the default 40-bit packet.
package mesh_term_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    GAP  = 2'd2
  } rx_state_t;

  // The field map is anchored at the MSB, so every offset follows from the packet width.
  function automatic int nxt_msb(input int w);
    return w - 1;
  endfunction

  function automatic int row_msb(input int w);
    return w - 9;
  endfunction

  function automatic int col_msb(input int w);
    return w - 13;
  endfunction

  function automatic int mode_bit(input int w);
    return w - 17;
  endfunction

  function automatic int pay_msb(input int w);
    return w - 18;
  endfunction

  typedef struct packed {
    logic [7:0]  nxtjp;
    logic [3:0]  row;
    logic [3:0]  colum;
    logic        mode;
    logic [22:0] payload;
  } mesh_hdr_t;

endpackage

// File: rtl/mesh_term_fifo.sv
// Show-ahead FIFO: rd_dat always presents the head entry; write and read in the
// same cycle leave level unchanged. Writes when full and reads when empty are ignored.
module mesh_term_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_wr, do_rd;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  assign rd_dat = mem_q[rd_ptr_q];
  assign level  = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: entries are only observed behind a valid level.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_dat;
  end

endmodule

// File: rtl/mesh_term_rx.sv
// Drains one mesh output port with a pop/gap cadence (one pop per 3 cycles), checks the
// destination and buffers accepted packets; pndng to out_valid is 2 cycles, stalls while full.
module mesh_term_rx
  import mesh_term_pkg::*;
#(
  parameter int         pckg_sz   = 40,
  parameter logic [3:0] ROW_ID    = 4'd0,
  parameter logic [3:0] COL_ID    = 4'd0,
  parameter int         BUF_DEPTH = 4,
  parameter int         CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pndng,
  input  logic [pckg_sz-1:0]           data_out,
  output logic                         pop,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [pckg_sz-1:0]           out_pkt,
  output logic                         out_mode,
  output logic [pckg_sz-18:0]          out_payload,
  output logic                         misroute,
  output logic [CNT_W-1:0]             pkt_cnt,
  output logic [CNT_W-1:0]             err_cnt,
  output logic [$clog2(BUF_DEPTH):0]   buf_level
);

  localparam int ROW_MSB  = row_msb(pckg_sz);
  localparam int COL_MSB  = col_msb(pckg_sz);
  localparam int MODE_BIT = mode_bit(pckg_sz);
  localparam int PAY_MSB  = pay_msb(pckg_sz);
  localparam int LVL_W    = $clog2(BUF_DEPTH) + 1;

  rx_state_t        state_q, state_d;
  logic             misroute_q, misroute_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [3:0]         cap_row, cap_col;
  logic               capture, dst_ok, wr_en, rd_en;
  logic               buf_full, buf_empty;
  logic [LVL_W-1:0]   buf_lvl;
  logic [pckg_sz-1:0] head_pkt;

  assign cap_row = data_out[ROW_MSB -: 4];
  assign cap_col = data_out[COL_MSB -: 4];
  assign dst_ok  = (cap_row == ROW_ID) && (cap_col == COL_ID);

  // data_out is consumed on the edge that closes the POP cycle.
  assign capture = (state_q == POP);
  assign wr_en   = capture && dst_ok;
  assign rd_en   = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pndng && !buf_full) state_d = POP;
      POP:     state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    err_cnt_d  = err_cnt_q;
    misroute_d = capture && !dst_ok;
    if (wr_en && (pkt_cnt_q != {CNT_W{1'b1}}))
      pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
    if (misroute_d && (err_cnt_q != {CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      misroute_q <= 1'b0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      misroute_q <= misroute_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  mesh_term_fifo #(
    .WIDTH (pckg_sz),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk    (clk),
    .rst    (reset),
    .wr_en  (wr_en),
    .wr_dat (data_out),
    .rd_en  (rd_en),
    .rd_dat (head_pkt),
    .level  (buf_lvl),
    .full   (buf_full),
    .empty  (buf_empty)
  );

  // pop is a decode of the state register, so reset removes it immediately.
  assign pop         = (state_q == POP);
  assign misroute    = misroute_q;
  assign pkt_cnt     = pkt_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign buf_level   = buf_lvl;
  assign out_valid   = !buf_empty;
  assign out_pkt     = head_pkt;
  assign out_mode    = head_pkt[MODE_BIT];
  assign out_payload = head_pkt[PAY_MSB:0];

endmodule

// File: tb/tb_mesh_term_rx.sv
// Bench for mesh_term_rx: a queue-driven mesh source model feeds the DUT, and a
// scoreboard of expected packets is checked against every consumer handshake.
module tb_mesh_term_rx;

  localparam int PW = 40;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          pndng;
  logic [PW-1:0] data_out;
  logic          pop;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_pkt;
  logic          out_mode;
  logic [PW-18:0] out_payload;
  logic          misroute;
  logic [CW-1:0] pkt_cnt;
  logic [CW-1:0] err_cnt;
  logic [2:0]    buf_level;

  mesh_term_rx #(
    .pckg_sz   (PW),
    .ROW_ID    (4'd0),
    .COL_ID    (4'd2),
    .BUF_DEPTH (4),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pndng       (pndng),
    .data_out    (data_out),
    .pop         (pop),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pkt     (out_pkt),
    .out_mode    (out_mode),
    .out_payload (out_payload),
    .misroute    (misroute),
    .pkt_cnt     (pkt_cnt),
    .err_cnt     (err_cnt),
    .buf_level   (buf_level)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [PW-1:0] src_q[$];
  logic [PW-1:0] exp_q[$];
  int            pop_cyc_q[$];
  int            cyc = 0;
  bit            pop_seen = 0;
  bit            pop_last = 0;
  int            pop_cnt = 0, mis_cnt = 0, mis_cyc = -1;
  int            vld_cycles = 0, first_vld = -1, delivered = 0;
  bit            hold_vld = 0;
  logic [PW-1:0] hold_pkt;

  function automatic logic [PW-1:0] mk(input logic [7:0] nxt, input logic [3:0] r,
                                        input logic [3:0] c, input logic m,
                                        input logic [22:0] pay);
    return {nxt, r, c, m, pay};
  endfunction

  function automatic void src_drive();
    pndng    = (src_q.size() != 0);
    data_out = (src_q.size() != 0) ? src_q[0] : '0;
  endfunction

  task automatic push(input logic [PW-1:0] p);
    src_q.push_back(p);
    if (p[31:28] == 4'd0 && p[27:24] == 4'd2) exp_q.push_back(p);
    src_drive();
  endtask

  task automatic clr_stats();
    pop_cyc_q.delete();
    pop_cnt = 0; mis_cnt = 0; mis_cyc = -1;
    vld_cycles = 0; first_vld = -1; delivered = 0;
    hold_vld = 0; pop_last = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    src_q.delete(); exp_q.delete(); pop_seen = 0;
    src_drive();
    repeat (3) @(posedge clk);
    #1;
    clr_stats();
    reset = 1'b0;
  endtask

  always @(posedge clk) cyc++;

  // Mesh source: the word presented during POP is retired after the DUT has sampled it.
  always @(posedge clk) begin
    #1;
    if (pop_seen) begin
      pop_seen = 0;
      if (src_q.size() != 0) void'(src_q.pop_front());
      src_drive();
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (pop) begin
        chk("pop_spacing", {63'd0, pop_last}, 64'd0);
        pop_cnt++;
        pop_cyc_q.push_back(cyc);
        pop_seen = 1;
      end
      pop_last = pop;
      if (misroute) begin
        mis_cnt++;
        mis_cyc = cyc;
      end
      if (out_valid) begin
        vld_cycles++;
        if (first_vld < 0) first_vld = cyc;
      end
      if (hold_vld && out_valid) chk("hold_stable", out_pkt, hold_pkt);
      hold_vld = out_valid && !out_ready;
      hold_pkt = out_pkt;
      if (out_valid && out_ready) begin
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          logic [PW-1:0] e;
          e = exp_q.pop_front();
          chk("out_pkt", out_pkt, e);
          chk("out_mode", out_mode, e[23]);
          chk("out_payload", out_payload, e[22:0]);
        end
        delivered++;
      end
    end
  end

  initial begin
    int pc;
    reset = 1'b1; pndng = 1'b0; data_out = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pop", pop, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_misroute", misroute, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_level", buf_level, 0);
    @(posedge clk); #1;
    clr_stats();
    reset = 1'b0;

    // Directed accept
    out_ready = 1'b1;
    @(posedge clk); #1;
    pc = cyc;
    push(mk(8'h00, 4'h0, 4'h2, 1'b1, 23'd1));
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("acc_pops", pop_cnt, 1);
    chk("acc_pop_lat", pop_cyc_q.size() > 0 ? pop_cyc_q[0] : -1, pc + 1);
    chk("acc_vld_lat", first_vld, pc + 2);
    chk("acc_vld_cycles", vld_cycles, 1);
    chk("acc_delivered", delivered, 1);
    chk("acc_pkt_cnt", pkt_cnt, 1);
    chk("acc_err_cnt", err_cnt, 0);
    chk("acc_misroute_cnt", mis_cnt, 0);

    // Misroute
    do_reset();
    out_ready = 1'b1;
    push(mk(8'h3C, 4'h1, 4'h2, 1'b0, 23'd7));
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("mis_pops", pop_cnt, 1);
    chk("mis_pulses", mis_cnt, 1);
    chk("mis_timing", mis_cyc, pop_cyc_q.size() > 0 ? pop_cyc_q[0] + 1 : -1);
    chk("mis_vld_cycles", vld_cycles, 0);
    chk("mis_err_cnt", err_cnt, 1);
    chk("mis_pkt_cnt", pkt_cnt, 0);

    // Backpressure up to full, then drain
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push(mk(8'(8'hA0 + i), 4'h0, 4'h2, i[0], 23'(i)));
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("bp_pops", pop_cnt, 4);
    chk("bp_level", buf_level, 4);
    chk("bp_pop_low", pop, 0);
    chk("bp_delivered", delivered, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("bp_pops_all", pop_cnt, 6);
    chk("bp_delivered_all", delivered, 6);
    chk("bp_level_end", buf_level, 0);
    chk("bp_pkt_cnt", pkt_cnt, 6);

    // Spacing with pndng held high
    do_reset();
    out_ready = 1'b1;
    @(posedge clk); #1;
    pc = cyc;
    for (int i = 0; i < 3; i++) push(mk(8'h11, 4'h0, 4'h2, 1'b0, 23'(100 + i)));
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("sp_pops", pop_cyc_q.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("sp_pop_cycle", i < pop_cyc_q.size() ? pop_cyc_q[i] : -1, pc + 1 + 3 * i);

    // Reset asserted during POP
    do_reset();
    out_ready = 1'b1;
    push(mk(8'h00, 4'h0, 4'h2, 1'b1, 23'd55));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pop) break;
    end
    chk("rm_pop_reached", pop, 1);
    reset = 1'b1;
    #1;
    chk("rm_pop_drop", pop, 0);
    chk("rm_pkt_cnt", pkt_cnt, 0);
    chk("rm_level", buf_level, 0);
    chk("rm_valid", out_valid, 0);
    src_q.delete(); exp_q.delete(); pop_seen = 0;
    src_drive();
    repeat (2) @(posedge clk);
    #1;
    clr_stats();
    reset = 1'b0;
    push(mk(8'h00, 4'h0, 4'h2, 1'b0, 23'd56));
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rm_after_pkt_cnt", pkt_cnt, 1);
    chk("rm_after_delivered", delivered, 1);

    // Counter saturation
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(mk(8'(i), 4'h0, 4'h2, i[1], 23'(200 + i)));
    repeat (17 * 3 + 15) @(posedge clk);
    @(negedge clk);
    chk("sat_pkt_cnt", pkt_cnt, 4'hF);
    chk("sat_delivered", delivered, 17);
    chk("sat_err_cnt", err_cnt, 0);
    chk("sat_sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mesh_term_rx.md
Name: mesh_term_rx

Overview:
- Terminal-side receiver that drains one mesh_gnrtr output port (pndng/data_out/pop) and decodes each packet into its header fields.
- Checks the destination against its own row/column, then buffers accepted packets for a downstream consumer using a valid/ready handshake.
- Sits at each mesh terminal, opposite the source that drives data_out_i_in/pndng_i_in. It replaces hand-driven pop pulses in benches and system tops.

Parameters:
pckg_sz, 40, packet width in bits
ROW_ID, 0, row address of this terminal (4 bits)
COL_ID, 0, column address of this terminal (4 bits)
BUF_DEPTH, 4, depth of internal packet buffer (power of two, >=2)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
pndng  in  1  mesh output FIFO non-empty; data_out valid while high
data_out  in  pckg_sz  head word of mesh output FIFO
pop  out  1  single-cycle pop to mesh output FIFO
out_valid  out  1  buffered packet available
out_ready  in  1  consumer accepts packet when out_valid&out_ready
out_pkt  out  pckg_sz  full packet at buffer head
out_mode  out  1  mode bit of head packet
out_payload  out  pckg_sz-17  payload of head packet
misroute  out  1  one-cycle pulse: dropped packet with wrong destination
pkt_cnt  out  CNT_W  accepted-packet count
err_cnt  out  CNT_W  misrouted-packet count
buf_level  out  $clog2(BUF_DEPTH)+1  current buffer occupancy

Behaviour:
- Field map: Nxtjp [pckg_sz-1:pckg_sz-8]; row [pckg_sz-9:pckg_sz-12]; colum [pckg_sz-13:pckg_sz-16]; mode [pckg_sz-17]; payload [pckg_sz-18:0].
- Reset (asynchronous, active-high): FSM enters IDLE; pop=0, out_valid=0, misroute=0, pkt_cnt=0, err_cnt=0, buf_level=0; buffer pointers cleared.
- Reset asserted mid-operation: pop drops in the same cycle; any captured but uncounted packet is lost.
- FSM states are IDLE, POP, GAP.
  - IDLE: if pndng=1 and buf_level<BUF_DEPTH, go to POP; otherwise stay. buf_level is sampled before any same-cycle consumer drain, which is conservative.
  - POP: pop=1 (registered output, asserted for exactly one cycle). data_out is sampled at the end of this cycle. Next state is GAP.
  - GAP: pop=0 for one cycle so the mesh pndng can update. Next state is IDLE.
- pop rules: never asserted while pndng=0 at the IDLE decision. Maximum rate is one pop per 3 cycles.
- Latency: pndng rises in cycle N -> pop high in N+1 -> out_valid high in N+2, provided the packet is accepted and the buffer was empty.
- Destination check on the captured word:
  - row==ROW_ID and colum==COL_ID: write to buffer; pkt_cnt+1.
  - otherwise: do not write; err_cnt+1; misroute=1 in the cycle after capture.
- Counters saturate at all-ones; no wrap.
- Buffer: show-ahead FIFO. out_pkt, out_mode and out_payload are taken from the head and are valid whenever out_valid=1.
  - Read occurs on out_valid&out_ready.
  - Simultaneous write and read: buf_level unchanged, ordering preserved.
- Buffer full: the FSM stays in IDLE. pndng is ignored and no pop is issued until a read frees an entry.
- out_pkt is held stable while out_valid=1 and out_ready=0.
- Nxtjp is passed through unchanged in out_pkt. The block does not interpret it.

Decomposition:
- Shared package mesh_term_pkg holds:
  - field offset constants as functions of pckg_sz (NXT_MSB, ROW_MSB, COL_MSB, MODE_BIT, PAY_MSB);
  - rx_state_t enum {IDLE, POP, GAP};
  - the packet-header struct typedef used by benches.
- One sub-module, mesh_term_fifo: synchronous show-ahead FIFO with parameters width and depth. It provides wr_en, rd_en, level, full and empty, and uses an asynchronous active-high reset.

Test Plan:
- Directed accept: ROW_ID=0, COL_ID=2; data_out={8'h00,4'h0,4'h2,1'b1,23'd1} with pndng=1 for one pop, out_ready=1 -> exactly one pop pulse; out_valid for 1 cycle; out_payload=1; out_mode=1; pkt_cnt=1; err_cnt=0.
- Misroute: same terminal; packet with row=1, colum=2 -> one pop; misroute pulse; out_valid stays 0; err_cnt=1; pkt_cnt=0.
- Backpressure/full: BUF_DEPTH=4, out_ready=0, six valid packets queued behind pndng -> exactly 4 pops; buf_level=4; pop stays 0. Then raise out_ready -> remaining 2 popped; 6 packets delivered in order with payloads 1..6.
- Spacing: pndng held high continuously with 3 packets -> pop pulses at cycles N+1, N+4, N+7; never on consecutive cycles.
- Reset mid-operation: assert reset in the POP cycle -> pop falls immediately; counters and buf_level are 0. After release, the next packet is accepted normally with pkt_cnt=1.
- Saturation: CNT_W=4, 17 accepted packets -> pkt_cnt stops at 4'hF.
